// File: rtl/mips_mem_pkg.sv
// Shared widths, arbiter state codes and request latch layout for the data-memory path.
package mips_mem_pkg;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

   // CPU has priority unless port 1 has waited through STARVE_MAX CPU grants.
   function automatic logic m1_wins(input logic m0_req, input logic m1_req, input logic starved);
      return m1_req & (~m0_req | starved);
   endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of CPU grants taken while port 1 was waiting.
module arb_starve_ctr #(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc_i,
   input  logic clr_i,
   output logic at_max_o
);

   localparam int CW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;
   localparam logic [CW-1:0] MAX_V = CW'(STARVE_MAX);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != MAX_V)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_max_o = (cnt_q == MAX_V);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port Data_Memory: CPU priority with a
// starvation guard for port 1, req/ack handshake per port.
module dmem_arbiter
   import mips_mem_pkg::*;
#(
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_wr,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_ack,
   output logic              m0_stall,
   input  logic              m1_req,
   input  logic              m1_wr,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_ack,
   output logic              dm_cs,
   output logic              dm_wr,
   output logic              dm_rd,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_din,
   input  logic [DATA_W-1:0] dm_dout,
   output logic              owner
);

   localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [LW-1:0] LAST = LW'(MEM_LAT - 1);

   arb_state_t        state_q, state_d;
   mem_req_t          req_q, req_d;
   logic              winner_q, winner_d;
   logic              owner_q, owner_d;
   logic [LW-1:0]     lat_q, lat_d;
   logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
   logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
   logic              starved, starve_inc, starve_clr;

   arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
      .clk      (clk),
      .rst      (rst),
      .inc_i    (starve_inc),
      .clr_i    (starve_clr),
      .at_max_o (starved)
   );

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      winner_d   = winner_q;
      owner_d    = owner_q;
      lat_d      = lat_q;
      m0_rdata_d = m0_rdata_q;
      m1_rdata_d = m1_rdata_q;
      starve_inc = 1'b0;
      starve_clr = 1'b0;
      case (state_q)
         ST_ACCESS: begin
            if (lat_q == LAST) begin
               state_d = ST_DONE;
               if (!req_q.wr) begin
                  if (winner_q) m1_rdata_d = dm_dout;
                  else          m0_rdata_d = dm_dout;
               end
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         // Encoding 2'd3 is unreachable but falls back to idle behaviour.
         default: begin
            starve_clr = ~m1_req;
            if (m0_req || m1_req) begin
               winner_d    = m1_wins(m0_req, m1_req, starved);
               owner_d     = winner_d;
               req_d.wr    = winner_d ? m1_wr    : m0_wr;
               req_d.addr  = winner_d ? m1_addr  : m0_addr;
               req_d.wdata = winner_d ? m1_wdata : m0_wdata;
               lat_d       = '0;
               state_d     = ST_ACCESS;
               if (winner_d) starve_clr = 1'b1;
               else          starve_inc = m1_req;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         req_q      <= '0;
         winner_q   <= 1'b0;
         owner_q    <= 1'b0;
         lat_q      <= '0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         winner_q   <= winner_d;
         owner_q    <= owner_d;
         lat_q      <= lat_d;
         m0_rdata_q <= m0_rdata_d;
         m1_rdata_q <= m1_rdata_d;
      end
   end

   // Strobes decode straight from the state register so reset kills dm_wr at once.
   assign dm_cs    = (state_q == ST_ACCESS);
   assign dm_wr    = dm_cs & req_q.wr;
   assign dm_rd    = dm_cs & ~req_q.wr;
   assign dm_addr  = dm_cs ? req_q.addr  : '0;
   assign dm_din   = dm_cs ? req_q.wdata : '0;
   assign m0_ack   = (state_q == ST_DONE) & ~winner_q;
   assign m1_ack   = (state_q == ST_DONE) & winner_q;
   assign m0_stall = m0_req & ~m0_ack;
   assign m0_rdata = m0_rdata_q;
   assign m1_rdata = m1_rdata_q;
   assign owner    = owner_q;

endmodule
